// File: rtl/hwpe_ctrl_regfile_arb_package.sv
// rtl/hwpe_ctrl_regfile_arb_package.sv - shared types and constants for the regfile arbiter
package hwpe_ctrl_regfile_arb_package;

  localparam int ARB_ADDR_WIDTH = 5;
  localparam int ARB_DATA_WIDTH = 32;
  localparam int ARB_NUM_BYTE   = ARB_DATA_WIDTH / 8;

  localparam int PORT_A = 0;
  localparam int PORT_B = 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    CLEAR  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  typedef struct packed {
    logic                      req;
    logic                      we;
    logic [ARB_ADDR_WIDTH-1:0] addr;
    logic [ARB_DATA_WIDTH-1:0] wdata;
    logic [ARB_NUM_BYTE-1:0]   be;
  } port_req_t;

endpackage

// File: rtl/hwpe_ctrl_rr_arb2.sv
// rtl/hwpe_ctrl_rr_arb2.sv - two-way round-robin arbiter, pointer advances only on contention
module hwpe_ctrl_rr_arb2
  import hwpe_ctrl_regfile_arb_package::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt,
  output logic       ptr
);

  logic contended;

  assign contended = enable & req[PORT_A] & req[PORT_B];

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (contended) begin
        gnt[PORT_A] = ~ptr;
        gnt[PORT_B] = ptr;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (contended) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/hwpe_ctrl_regfile_arbiter.sv
// rtl/hwpe_ctrl_regfile_arbiter.sv - shares one regfile between two requesters with clear sequencing
module hwpe_ctrl_regfile_arbiter
  import hwpe_ctrl_regfile_arb_package::*;
#(
  parameter  int ADDR_WIDTH = 5,
  parameter  int DATA_WIDTH = 32,
  localparam int NUM_BYTE   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  a_req_i,
  output logic                  a_gnt_o,
  input  logic                  a_we_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_wdata_i,
  input  logic [NUM_BYTE-1:0]   a_be_i,
  output logic                  a_r_valid_o,
  output logic [DATA_WIDTH-1:0] a_r_data_o,
  input  logic                  b_req_i,
  output logic                  b_gnt_o,
  input  logic                  b_we_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [DATA_WIDTH-1:0] b_wdata_i,
  input  logic [NUM_BYTE-1:0]   b_be_i,
  output logic                  b_r_valid_o,
  output logic [DATA_WIDTH-1:0] b_r_data_o,
  output logic                  rf_clear_o,
  output logic                  rf_read_enable_o,
  output logic [ADDR_WIDTH-1:0] rf_read_addr_o,
  input  logic [DATA_WIDTH-1:0] rf_read_data_i,
  output logic                  rf_write_enable_o,
  output logic [ADDR_WIDTH-1:0] rf_write_addr_o,
  output logic [DATA_WIDTH-1:0] rf_write_data_o,
  output logic [NUM_BYTE-1:0]   rf_write_be_o,
  output logic                  busy_o
);

  state_t                state;
  logic                  hz_valid;
  logic [ADDR_WIDTH-1:0] hz_addr;
  logic                  rsp_a, rsp_b, rsp_read;
  logic [1:0]            elig, gnt;
  logic                  arb_en, any_gnt, sel_b, sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  rr_ptr_unused;

  // A read of the address written last cycle would see stale regfile data.
  always_comb begin
    elig = 2'b00;
    elig[PORT_A] = a_req_i & ~(hz_valid & ~a_we_i & (a_addr_i == hz_addr));
    elig[PORT_B] = b_req_i & ~(hz_valid & ~b_we_i & (b_addr_i == hz_addr));
  end

  assign arb_en = (state == RUN) & ~clear_i & ~rst;

  hwpe_ctrl_rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .req    (elig),
    .enable (arb_en),
    .gnt    (gnt),
    .ptr    (rr_ptr_unused)
  );

  assign a_gnt_o  = gnt[PORT_A];
  assign b_gnt_o  = gnt[PORT_B];
  assign any_gnt  = |gnt;
  assign sel_b    = gnt[PORT_B];
  assign sel_we   = sel_b ? b_we_i : a_we_i;
  assign sel_addr = sel_b ? b_addr_i : a_addr_i;

  assign rf_read_enable_o  = any_gnt & ~sel_we;
  assign rf_read_addr_o    = rf_read_enable_o ? sel_addr : '0;
  assign rf_write_enable_o = any_gnt & sel_we;
  assign rf_write_addr_o   = rf_write_enable_o ? sel_addr : '0;
  assign rf_write_data_o   = rf_write_enable_o ? (sel_b ? b_wdata_i : a_wdata_i) : '0;
  assign rf_write_be_o     = rf_write_enable_o ? (sel_b ? b_be_i : a_be_i) : '0;

  assign a_r_valid_o = rsp_a;
  assign b_r_valid_o = rsp_b;
  assign a_r_data_o  = (rsp_a & rsp_read) ? rf_read_data_i : '0;
  assign b_r_data_o  = (rsp_b & rsp_read) ? rf_read_data_i : '0;

  // Responses are not cancelled by clear: an accepted access always completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_a    <= 1'b0;
      rsp_b    <= 1'b0;
      rsp_read <= 1'b0;
      hz_valid <= 1'b0;
      hz_addr  <= '0;
    end else begin
      rsp_a    <= gnt[PORT_A];
      rsp_b    <= gnt[PORT_B];
      rsp_read <= any_gnt & ~sel_we;
      hz_valid <= rf_write_enable_o;
      hz_addr  <= sel_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      rf_clear_o <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (clear_i) begin
            state      <= CLEAR;
            rf_clear_o <= 1'b1;
            busy_o     <= 1'b1;
          end
        end
        CLEAR: begin
          busy_o <= 1'b1;
          if (clear_i) begin
            state      <= CLEAR;
            rf_clear_o <= 1'b1;
          end else begin
            state      <= SETTLE;
            rf_clear_o <= 1'b0;
          end
        end
        SETTLE: begin
          if (clear_i) begin
            state      <= CLEAR;
            rf_clear_o <= 1'b1;
            busy_o     <= 1'b1;
          end else begin
            state      <= RUN;
            rf_clear_o <= 1'b0;
            busy_o     <= 1'b0;
          end
        end
        default: begin
          state      <= RUN;
          rf_clear_o <= 1'b0;
          busy_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hwpe_ctrl_regfile_arbiter.sv
// tb/tb_hwpe_ctrl_regfile_arbiter.sv - scoreboard bench with a behavioural latch regfile
module tb_hwpe_ctrl_regfile_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_i;
  logic        a_req_i, a_gnt_o, a_we_i, a_r_valid_o;
  logic [4:0]  a_addr_i;
  logic [31:0] a_wdata_i, a_r_data_o;
  logic [3:0]  a_be_i;
  logic        b_req_i, b_gnt_o, b_we_i, b_r_valid_o;
  logic [4:0]  b_addr_i;
  logic [31:0] b_wdata_i, b_r_data_o;
  logic [3:0]  b_be_i;
  logic        rf_clear_o, rf_read_enable_o, rf_write_enable_o, busy_o;
  logic [4:0]  rf_read_addr_o, rf_write_addr_o;
  logic [31:0] rf_read_data_i, rf_write_data_o;
  logic [3:0]  rf_write_be_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } rsp_t;
  rsp_t        sb[$];
  rsp_t        it;
  logic [31:0] ref_mem [32];
  logic        ev_a, ev_b;
  logic [31:0] ed_a, ed_b;

  logic [31:0] mem [32];
  logic        wr_pend;
  logic [4:0]  wr_addr_q;
  logic [31:0] wr_data_q;
  logic [3:0]  wr_be_q;

  always #5 clk = ~clk;

  hwpe_ctrl_regfile_arbiter dut (
    .clk (clk), .rst (rst), .clear_i (clear_i),
    .a_req_i (a_req_i), .a_gnt_o (a_gnt_o), .a_we_i (a_we_i), .a_addr_i (a_addr_i),
    .a_wdata_i (a_wdata_i), .a_be_i (a_be_i), .a_r_valid_o (a_r_valid_o), .a_r_data_o (a_r_data_o),
    .b_req_i (b_req_i), .b_gnt_o (b_gnt_o), .b_we_i (b_we_i), .b_addr_i (b_addr_i),
    .b_wdata_i (b_wdata_i), .b_be_i (b_be_i), .b_r_valid_o (b_r_valid_o), .b_r_data_o (b_r_data_o),
    .rf_clear_o (rf_clear_o), .rf_read_enable_o (rf_read_enable_o), .rf_read_addr_o (rf_read_addr_o),
    .rf_read_data_i (rf_read_data_i), .rf_write_enable_o (rf_write_enable_o),
    .rf_write_addr_o (rf_write_addr_o), .rf_write_data_o (rf_write_data_o),
    .rf_write_be_o (rf_write_be_o), .busy_o (busy_o)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Regfile: write lands two cycles after grant, read data registered one cycle after capture.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pend <= 1'b0;
    end else begin
      if (rf_clear_o) begin
        for (int i = 0; i < 32; i++) mem[i] <= '0;
      end else if (wr_pend) begin
        mem[wr_addr_q] <= merge(mem[wr_addr_q], wr_data_q, wr_be_q);
      end
      wr_pend   <= rf_write_enable_o;
      wr_addr_q <= rf_write_addr_o;
      wr_data_q <= rf_write_data_o;
      wr_be_q   <= rf_write_be_o;
      if (rf_read_enable_o) rf_read_data_i <= mem[rf_read_addr_o];
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      ev_a = 1'b0; ev_b = 1'b0; ed_a = '0; ed_b = '0;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        if (it.port) begin ev_b = 1'b1; ed_b = it.data; end
        else begin ev_a = 1'b1; ed_a = it.data; end
      end
      if (ev_a || a_r_valid_o) begin
        check("sb_a_r_valid", a_r_valid_o, ev_a);
        check("sb_a_r_data", a_r_data_o, ed_a);
      end
      if (ev_b || b_r_valid_o) begin
        check("sb_b_r_valid", b_r_valid_o, ev_b);
        check("sb_b_r_data", b_r_data_o, ed_b);
      end
      if (a_gnt_o || b_gnt_o) check("single_gnt", a_gnt_o & b_gnt_o, 0);
      if (a_req_i && a_gnt_o) begin
        it.port = 1'b0;
        it.data = a_we_i ? 32'h0 : ref_mem[a_addr_i];
        sb.push_back(it);
        if (a_we_i) ref_mem[a_addr_i] = merge(ref_mem[a_addr_i], a_wdata_i, a_be_i);
      end
      if (b_req_i && b_gnt_o) begin
        it.port = 1'b1;
        it.data = b_we_i ? 32'h0 : ref_mem[b_addr_i];
        sb.push_back(it);
        if (b_we_i) ref_mem[b_addr_i] = merge(ref_mem[b_addr_i], b_wdata_i, b_be_i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic req, input logic we, input logic [4:0] addr, input logic [31:0] d, input logic [3:0] be);
    a_req_i = req; a_we_i = we; a_addr_i = addr; a_wdata_i = d; a_be_i = be;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [4:0] addr, input logic [31:0] d, input logic [3:0] be);
    b_req_i = req; b_we_i = we; b_addr_i = addr; b_wdata_i = d; b_be_i = be;
  endtask

  task automatic a_access(input logic we, input logic [4:0] addr, input logic [31:0] d, input logic [3:0] be);
    int n = 0;
    set_a(1'b1, we, addr, d, be);
    @(negedge clk);
    while (!a_gnt_o && n < 10) begin
      step();
      @(negedge clk);
      n++;
    end
    check("a_access_gnt", a_gnt_o, 1);
    step();
    set_a(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 32; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    rf_read_data_i = '0;
    rst = 1'b1; clear_i = 1'b0;
    set_a(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
    set_b(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
    #2;
    check("rst_a_gnt", a_gnt_o, 0);
    check("rst_a_r_valid", a_r_valid_o, 0);
    check("rst_b_r_valid", b_r_valid_o, 0);
    check("rst_rf_clear", rf_clear_o, 0);
    check("rst_busy", busy_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // single write then read on A
    step();
    set_a(1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    check("t1_wr_gnt", a_gnt_o, 1);
    check("t1_rf_we", rf_write_enable_o, 1);
    check("t1_rf_waddr", rf_write_addr_o, 3);
    check("t1_rf_wdata", rf_write_data_o, 32'hDEADBEEF);
    step();
    set_a(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
    @(negedge clk);
    check("t1_wr_rsp", a_r_valid_o, 1);
    step(); step();
    set_a(1'b1, 1'b0, 5'd3, 32'h0, 4'h0);
    @(negedge clk);
    check("t1_rd_gnt", a_gnt_o, 1);
    check("t1_rf_re", rf_read_enable_o, 1);
    step();
    set_a(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
    @(negedge clk);
    check("t1_rd_data", a_r_data_o, 32'hDEADBEEF);
    check("t1_b_quiet", b_r_valid_o, 0);

    // contention: pointer still at A
    step();
    set_a(1'b1, 1'b0, 5'd7, 32'h0, 4'h0);
    set_b(1'b1, 1'b0, 5'd8, 32'h0, 4'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("cont_a_gnt", a_gnt_o, (k % 2) == 0);
      check("cont_b_gnt", b_gnt_o, (k % 2) == 1);
      step();
    end
    set_a(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
    set_b(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
    step(); step();

    // read-after-write hazard on the same address stalls one cycle
    set_a(1'b1, 1'b1, 5'd5, 32'h12345678, 4'hF);
    @(negedge clk);
    check("hz_wr_gnt", a_gnt_o, 1);
    step();
    set_a(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
    set_b(1'b1, 1'b0, 5'd5, 32'h0, 4'h0);
    @(negedge clk);
    check("hz_stall", b_gnt_o, 0);
    step();
    @(negedge clk);
    check("hz_gnt", b_gnt_o, 1);
    step();
    set_b(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
    @(negedge clk);
    check("hz_valid", b_r_valid_o, 1);
    check("hz_data", b_r_data_o, 32'h12345678);
    step();
    set_a(1'b1, 1'b1, 5'd5, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    check("hz2_wr_gnt", a_gnt_o, 1);
    step();
    set_a(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
    set_b(1'b1, 1'b0, 5'd6, 32'h0, 4'h0);
    @(negedge clk);
    check("hz2_other_gnt", b_gnt_o, 1);
    step();
    set_b(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
    @(negedge clk);
    check("hz2_data", b_r_data_o, 32'h0);
    step();

    // byte enables, including an all-zero mask
    a_access(1'b1, 5'd1, 32'hFFFFFFFF, 4'hF);
    a_access(1'b1, 5'd1, 32'h000000AA, 4'b0001);
    a_access(1'b1, 5'd1, 32'h12121212, 4'b0000);
    step(); step();
    a_access(1'b0, 5'd1, 32'h0, 4'h0);
    @(negedge clk);
    check("be_read", a_r_data_o, 32'hFFFFFFAA);
    step();

    // clear sequencing
    for (int i = 0; i < 4; i++) a_access(1'b1, i[4:0], 32'h100 + i, 4'hF);
    step(); step();
    clear_i = 1'b1;
    set_a(1'b1, 1'b0, 5'd2, 32'h0, 4'h0);
    @(negedge clk);
    check("clr_gnt0", a_gnt_o, 0);
    check("clr_busy0", busy_o, 0);
    step();
    clear_i = 1'b0;
    @(negedge clk);
    check("clr_rf_clear1", rf_clear_o, 1);
    check("clr_busy1", busy_o, 1);
    check("clr_gnt1", a_gnt_o, 0);
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    step();
    @(negedge clk);
    check("clr_rf_clear2", rf_clear_o, 0);
    check("clr_busy2", busy_o, 1);
    check("clr_gnt2", a_gnt_o, 0);
    step();
    @(negedge clk);
    check("clr_gnt3", a_gnt_o, 1);
    check("clr_busy3", busy_o, 0);
    step();
    set_a(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
    @(negedge clk);
    check("clr_rd_valid", a_r_valid_o, 1);
    check("clr_rd_data", a_r_data_o, 32'h0);
    step();

    // async reset between a grant and its response
    set_a(1'b1, 1'b0, 5'd1, 32'h0, 4'h0);
    set_b(1'b1, 1'b0, 5'd9, 32'h0, 4'h0);
    n = 0;
    @(negedge clk);
    while (!a_gnt_o && n < 4) begin
      step();
      @(negedge clk);
      n++;
    end
    check("rst_pre_a_gnt", a_gnt_o, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstm_a_valid", a_r_valid_o, 0);
    check("rstm_a_data", a_r_data_o, 32'h0);
    check("rstm_a_gnt", a_gnt_o, 0);
    check("rstm_b_gnt", b_gnt_o, 0);
    check("rstm_rf_re", rf_read_enable_o, 0);
    check("rstm_rf_raddr", rf_read_addr_o, 0);
    check("rstm_busy", busy_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstm_post_a_valid", a_r_valid_o, 0);
    check("rstm_post_b_valid", b_r_valid_o, 0);
    check("rstm_ptr_a", a_gnt_o, 1);
    check("rstm_ptr_b", b_gnt_o, 0);
    step();
    set_a(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
    set_b(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
    repeat (4) step();
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
